// File: rtl/cfg_loader_pkg.sv
// Shared types and defaults for the configuration scan-chain loader.
// A default chain is one SB: WIDTH*4*2 bits.
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        SHIFT     = 3'd2,
        VERIFY    = 3'd3,
        DONE      = 3'd4
    } state_t;

    function automatic int sb_chain_len(input int width);
        return width * 4 * 2;
    endfunction

    localparam int SB_WIDTH_DEF  = 32;
    localparam int CHAIN_LEN_DEF = sb_chain_len(SB_WIDTH_DEF);

endpackage

// File: rtl/cfg_word_serializer.sv
// Holds one configuration word and emits its top nbits MSB-first.
// Everything stalls while en is low.
module cfg_word_serializer #(
    parameter int WORD_W = 32,
    parameter int NB_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    input  logic [NB_W-1:0]   nbits,
    output logic              bit_out,
    output logic              last
);

    logic [WORD_W-1:0] shreg;
    logic [NB_W-1:0]   remain;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            remain <= '0;
        end else if (en) begin
            if (load) begin
                shreg  <= word;
                remain <= nbits;
            end else if (shift) begin
                shreg  <= shreg << 1;
                remain <= remain - NB_W'(1);
            end
        end
    end

    assign bit_out = shreg[WORD_W-1];
    assign last    = (remain == NB_W'(1));

endmodule

// File: rtl/cfg_chain_loader.sv
// Feeds configuration words serially into a scan chain, MSB-first.
// Define CFG_READBACK_EN to add a rotate-and-count VERIFY pass.
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_data_out,
    output logic              cfg_en_out,
    input  logic              cfg_chain_return,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BIT_CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int NB_W      = $clog2(WORD_W + 1);

    state_t               state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [NB_W-1:0]      nbits;
    logic                 accept;
    logic                 shifting;
    logic                 ser_bit;
    logic                 ser_last;
    logic                 last_bit;
    int                   rem;

    assign accept   = en && (state == WAIT_WORD) && word_valid;
    assign shifting = en && (state == SHIFT);
    assign last_bit = (bit_cnt == BIT_CNT_W'(CHAIN_LEN - 1));

    // The final word may carry more bits than the chain still needs.
    always_comb begin
        rem   = CHAIN_LEN - int'(bit_cnt);
        nbits = NB_W'(WORD_W);
        if (rem < WORD_W) nbits = NB_W'(rem);
    end

    cfg_word_serializer #(
        .WORD_W (WORD_W),
        .NB_W   (NB_W)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (accept),
        .shift   (shifting),
        .word    (word_in),
        .nbits   (nbits),
        .bit_out (ser_bit),
        .last    (ser_last)
    );

`ifdef CFG_READBACK_EN
    logic [BIT_CNT_W-1:0] load_ones;
    logic [BIT_CNT_W-1:0] rb_ones;
    logic                 error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            load_ones <= '0;
            rb_ones   <= '0;
            error_q   <= 1'b0;
        end else if (en) begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WAIT_WORD;
                        bit_cnt   <= '0;
                        load_ones <= '0;
                        rb_ones   <= '0;
                        error_q   <= 1'b0;
                    end
                end
                WAIT_WORD: begin
                    if (word_valid) state <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                    load_ones <= load_ones + BIT_CNT_W'(ser_bit);
                    if (ser_last) begin
                        if (last_bit) begin
                            state   <= VERIFY;
                            bit_cnt <= '0;
                        end else begin
                            state <= WAIT_WORD;
                        end
                    end
                end
                VERIFY: begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    rb_ones <= rb_ones + BIT_CNT_W'(cfg_chain_return);
                    if (last_bit) begin
                        state   <= DONE;
                        error_q <= load_ones !=
                                   (rb_ones + BIT_CNT_W'(cfg_chain_return));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign error      = error_q;
    assign cfg_en_out = en && ((state == SHIFT) || (state == VERIFY));
    assign busy       = (state == WAIT_WORD) || (state == SHIFT)
                     || (state == VERIFY);

    // Rotating the tail back in leaves the loaded pattern intact.
    always_comb begin
        cfg_data_out = 1'b0;
        if (state == SHIFT)  cfg_data_out = ser_bit;
        if (state == VERIFY) cfg_data_out = cfg_chain_return;
    end
`else
    logic unused_ret;

    assign unused_ret = cfg_chain_return;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else if (en) begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= WAIT_WORD;
                        bit_cnt <= '0;
                    end
                end
                WAIT_WORD: begin
                    if (word_valid) state <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    if (ser_last) state <= last_bit ? DONE : WAIT_WORD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign error        = 1'b0;
    assign cfg_en_out   = en && (state == SHIFT);
    assign cfg_data_out = (state == SHIFT) && ser_bit;
    assign busy         = (state == WAIT_WORD) || (state == SHIFT);
`endif

    assign word_ready = en && (state == WAIT_WORD);
    assign done       = (state == DONE);

endmodule
